peak_hold_bargraph: RTL and testbench



---
 rtl/peak_hold_bargraph.sv | 124 ++++++++++++
 tb/tb_peak_hold_bargraph.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/peak_hold_bargraph.sv
// Pushbutton bargraph with peak-hold, timed hold, stepwise decay and display freeze.
// Define PEAK_MARK_EN to show the live level as a bar with the held peak as a marker bit.
module peak_hold_bargraph #(
    parameter int WIDTH       = 16,
    parameter int HOLD_TICKS  = 100,
    parameter int DECAY_TICKS = 10,
    localparam int LW         = $clog2(WIDTH + 1)
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [WIDTH-1:0] pb,
    input  logic             mode,
    input  logic             freeze,
    output logic [WIDTH-1:0] bar,
    output logic [LW-1:0]    level,
    output logic             holding
);

    localparam int MAXT = (HOLD_TICKS > DECAY_TICKS) ? HOLD_TICKS : DECAY_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, DECAY} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            holding_q;
    logic [LW-1:0]   live;

    function automatic logic [WIDTH-1:0] thermo(input logic [LW-1:0] n);
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) t[i] = (LW'(i) < n);
        return t;
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [LW-1:0] n);
        logic [WIDTH-1:0] o;
        for (int i = 0; i < WIDTH; i++) o[i] = (n == LW'(i + 1));
        return o;
    endfunction

    // Highest pressed button wins; later iterations override lower bits.
    always_comb begin
        live = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pb[i]) live = LW'(i + 1);
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            if (live != '0 && live >= d_q) begin
                d_d     = live;
                cnt_d   = '0;
                state_d = TRACK;
            end else begin
                case (state_q)
                    TRACK: begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                    HOLD: begin
                        if (cnt_q == CW'(HOLD_TICKS - 1)) begin
                            state_d = DECAY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    DECAY: begin
                        if (cnt_q == CW'(DECAY_TICKS - 1)) begin
                            d_d   = d_q - LW'(1);
                            cnt_d = '0;
                            // Decay stops once it meets the live level.
                            if (d_q - LW'(1) == live) begin
                                state_d = (live == '0) ? IDLE : TRACK;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            d_q       <= '0;
            cnt_q     <= '0;
            holding_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            holding_q <= (state_d == HOLD) || (state_d == DECAY);
        end
    end

    assign level   = d_q;
    assign holding = holding_q;

`ifdef PEAK_MARK_EN
    logic [LW-1:0] live_q;
    logic [LW-1:0] live_d;

    assign live_d = freeze ? live_q : live;

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) live_q <= '0;
        else        live_q <= live_d;
    end

    assign bar = mode ? onehot(d_q) : (thermo(live_q) | onehot(d_q));
`else
    assign bar = mode ? onehot(d_q) : thermo(d_q);
`endif

endmodule

// File: tb/tb_peak_hold_bargraph.sv
// Scoreboard bench for peak_hold_bargraph: a driver pushes expected outputs from a
// closed-form peak/age model, a monitor pops and compares after every rising edge.
module tb_peak_hold_bargraph;

    localparam int W   = 16;
    localparam int HT  = 4;
    localparam int DT  = 2;
    localparam int LWT = $clog2(W + 1);

    logic           hz100  = 1'b0;
    logic           reset  = 1'b0;
    logic [W-1:0]   pb     = '0;
    logic           mode   = 1'b0;
    logic           freeze = 1'b0;
    logic [W-1:0]   bar;
    logic [LWT-1:0] level;
    logic           holding;

    peak_hold_bargraph #(
        .WIDTH      (W),
        .HOLD_TICKS (HT),
        .DECAY_TICKS(DT)
    ) dut (
        .hz100  (hz100),
        .reset  (reset),
        .pb     (pb),
        .mode   (mode),
        .freeze (freeze),
        .bar    (bar),
        .level  (level),
        .holding(holding)
    );

    always #5 hz100 = ~hz100;

    typedef struct {
        int bar;
        int level;
        int hold;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: peak P, age A = edges since the level first fell below the peak (0 = not holding).
    int mP  = 0;
    int mA  = 0;
    int mLq = 0;

    function automatic int live_of(input logic [W-1:0] v);
        int l = 0;
        for (int i = 0; i < W; i++) if (v[i]) l = i + 1;
        return l;
    endfunction

    function automatic int shown();
        int n;
        n = (mA > HT) ? (mA - 1 - HT) / DT : 0;
        return mP - n;
    endfunction

    function automatic int thermo_v(input int n);
        longint t;
        t = (longint'(1) << n) - longint'(1);
        return int'(t & longint'(32'hFFFF));
    endfunction

    function automatic int onehot_v(input int n);
        longint t;
        if (n == 0) return 0;
        t = longint'(1) << (n - 1);
        return int'(t);
    endfunction

    function automatic exp_t expect_now(input logic m);
        exp_t e;
        int d;
        d = shown();
        e.level = d;
        e.hold  = (mA > 0) ? 1 : 0;
        if (m) e.bar = onehot_v(d);
        else begin
`ifdef PEAK_MARK_EN
            e.bar = thermo_v(mLq) | onehot_v(d);
`else
            e.bar = thermo_v(d);
`endif
        end
        return e;
    endfunction

    task automatic model_reset();
        mP = 0; mA = 0; mLq = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] p, input logic f);
        int l, dcur, dn;
        if (f) return;
        l = live_of(p);
        dcur = shown();
        if (l > 0 && l >= dcur) begin
            mP = l; mA = 0;
        end else if (mP > 0) begin
            mA = mA + 1;
            dn = shown();
            if (dn < dcur && dn == l) begin
                mP = l; mA = 0;
            end
        end
        mLq = l;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic rst_v, input logic [W-1:0] p, input logic m, input logic f);
        @(negedge hz100);
        reset = rst_v; pb = p; mode = m; freeze = f;
        if (!rst_v) model_reset();
        else        model_edge(p, f);
        q.push_back(expect_now(m));
    endtask

    // Monitor: outputs are stable 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge hz100);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("bar",     int'(bar),     e.bar);
                check("level",   int'(level),   e.level);
                check("holding", int'(holding), e.hold);
            end
        end
    end

    initial begin
        logic [W-1:0] p_prev;
        logic [W-1:0] p;
        int           k;
        p_prev = '0;

        pb = '1;
        #1;
        check("reset_bar",   int'(bar),     0);
        check("reset_level", int'(level),   0);
        check("reset_hold",  int'(holding), 0);
        step(0, '1, 0, 0);
        step(0, '1, 0, 0);

        step(1, 16'h0020, 0, 0);
        repeat (18) step(1, '0, 0, 0);

        step(1, 16'h0020, 0, 0);
        repeat (11) step(1, '0, 0, 0);
        step(1, 16'h0100, 0, 0);

        step(0, '0, 0, 0);
        step(1, 16'h0001, 1, 0);
        step(1, 16'h8000, 1, 0);
        step(1, 16'h8421, 0, 0);

        step(0, '0, 0, 0);
        step(1, 16'h0020, 0, 0);
        repeat (2) step(1, '0, 0, 0);
        repeat (20) step(1, '0, 0, 1);
        repeat (18) step(1, '0, 0, 0);
        step(1, 16'h0020, 0, 0);
        step(1, '0, 0, 0);
        repeat (3) step(1, 16'h8000, 0, 1);
        repeat (4) step(1, '0, 0, 0);

        step(1, 16'h0020, 0, 0);
        repeat (9) step(1, '0, 0, 0);
        @(negedge hz100);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_bar",   int'(bar),     0);
        check("async_rst_level", int'(level),   0);
        check("async_rst_hold",  int'(holding), 0);
        q.push_back(expect_now(mode));
        repeat (4) step(1, '0, 0, 0);

        step(0, '0, 0, 0);
        step(1, 16'h0002, 0, 0);
        step(1, 16'h0020, 0, 0);
        repeat (14) step(1, 16'h0002, 0, 0);

        repeat (3000) begin
            k = $urandom_range(0, 9);
            if (k < 5)       p = '0;
            else if (k < 7)  p = p_prev;
            else if (k == 7) p = W'($urandom);
            else             p = W'(32'd1 << $urandom_range(0, W - 1));
            p_prev = p;
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, p,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(negedge hz100);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
